pc_seq_ctrl: RTL

Next-address sequencer for the 8-bit program counter. It decodes one control op per cycle and drives the counter's jump/jumpaddr pair combinationally, so the counter picks the decision up at the same posedge. It holds a hardware return-address stack for CALL/RET and handles halt, a level-sensitive interrupt and stack-fault trapping. It sits between the instruction decoder and the program counter.

---
 rtl/pc_seq_ctrl_if.sv | 38 +++
 rtl/pc_seq_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_ctrl_if
// Brief    : Decoder/sequencer/counter signal bundle for pc_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_seq_ctrl_if #(
   parameter int DEPTH = 4
) ();
   localparam int SPW = $clog2(DEPTH) + 1;

   logic           op_valid;
   logic [2:0]     op;
   logic [7:0]     target;
   logic           zero;
   logic [7:0]     cur_addr;
   logic           irq;
   logic           jump;
   logic [7:0]     jumpaddr;
   logic           halted;
   logic           in_isr;
   logic           irq_ack;
   logic           fault;
   logic [SPW-1:0] sp;

   // Decoder/counter side
   modport master (
      output op_valid, op, target, zero, cur_addr, irq,
      input  jump, jumpaddr, halted, in_isr, irq_ack, fault, sp
   );

   // Sequencer side
   modport slave (
      input  op_valid, op, target, zero, cur_addr, irq,
      output jump, jumpaddr, halted, in_isr, irq_ack, fault, sp
   );
endinterface
`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_ctrl
// Brief    : PC next-address sequencer with return stack, halt, IRQ and
//            stack-fault trap. Interrupt logic enabled by `PC_SEQ_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_seq_ctrl #(
   parameter int         DEPTH     = 4,
   parameter logic [7:0] IRQ_VEC   = 8'hF0,
   parameter logic [7:0] FAULT_VEC = 8'hFE
) (
   input wire logic       clk,
   input wire logic       rst,
   pc_seq_ctrl_if.slave   seq_if
);
   localparam int SPW = $clog2(DEPTH) + 1;
   localparam int AW  = $clog2(DEPTH);
   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

`ifdef PC_SEQ_IRQ_EN
   localparam logic IRQ_EN = 1'b1;
`else
   localparam logic IRQ_EN = 1'b0;
`endif

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_JMP  = 3'd1;
   localparam logic [2:0] OP_JZ   = 3'd2;
   localparam logic [2:0] OP_JNZ  = 3'd3;
   localparam logic [2:0] OP_CALL = 3'd4;
   localparam logic [2:0] OP_RET  = 3'd5;
   localparam logic [2:0] OP_HALT = 3'd6;
   localparam logic [2:0] OP_RETI = 3'd7;

   typedef enum logic [0:0] {
      S_RUN    = 1'b0,
      S_HALTED = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic           in_isr_q, in_isr_d;
   logic           fault_q, fault_d;
   logic [7:0]     stack_q [DEPTH];

   logic           w_jump;
   logic [7:0]     w_jumpaddr;
   logic           w_irq_ack;
   logic           w_push;
   logic           w_pop;
   logic           w_trap;
   logic [7:0]     w_push_data;
   logic [AW-1:0]  w_top_idx;
   logic           w_full;
   logic           w_empty;
   logic           w_irq_take;

   assign w_top_idx  = sp_q[AW-1:0] - 1'b1;
   assign w_full     = (sp_q == SP_FULL);
   assign w_empty    = (sp_q == '0);
   assign w_irq_take = IRQ_EN && seq_if.irq && !in_isr_q && !fault_q;

   always_comb begin
      w_jump      = 1'b0;
      w_jumpaddr  = 8'h00;
      w_irq_ack   = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_trap      = 1'b0;
      w_push_data = 8'h00;
      state_d     = state_q;
      in_isr_d    = in_isr_q;
      fault_d     = fault_q;

      if (!rst) begin
         unique case (state_q)
            S_RUN: begin
               if (w_irq_take) begin
                  if (w_full) begin
                     w_trap = 1'b1;
                  end else begin
                     w_jump      = 1'b1;
                     w_jumpaddr  = IRQ_VEC;
                     w_push      = 1'b1;
                     w_push_data = seq_if.cur_addr;
                     in_isr_d    = 1'b1;
                     w_irq_ack   = 1'b1;
                  end
               end else if (seq_if.op_valid) begin
                  unique case (seq_if.op)
                     OP_NOP: w_jump = 1'b0;
                     OP_JMP: begin
                        w_jump     = 1'b1;
                        w_jumpaddr = seq_if.target;
                     end
                     OP_JZ: begin
                        w_jump     = seq_if.zero;
                        w_jumpaddr = seq_if.target;
                     end
                     OP_JNZ: begin
                        w_jump     = !seq_if.zero;
                        w_jumpaddr = seq_if.target;
                     end
                     OP_CALL: begin
                        if (w_full) begin
                           w_trap = 1'b1;
                        end else begin
                           w_jump      = 1'b1;
                           w_jumpaddr  = seq_if.target;
                           w_push      = 1'b1;
                           w_push_data = seq_if.cur_addr + 8'd1;
                        end
                     end
                     OP_RET, OP_RETI: begin
                        if (w_empty) begin
                           w_trap = 1'b1;
                        end else begin
                           w_jump     = 1'b1;
                           w_jumpaddr = stack_q[w_top_idx];
                           w_pop      = 1'b1;
                           if (IRQ_EN && seq_if.op == OP_RETI) begin
                              in_isr_d = 1'b0;
                           end
                        end
                     end
                     OP_HALT: begin
                        w_jump     = 1'b1;
                        w_jumpaddr = seq_if.cur_addr;
                        state_d    = S_HALTED;
                     end
                     default: w_jump = 1'b0;
                  endcase
               end
            end
            S_HALTED: begin
               w_jump     = 1'b1;
               w_jumpaddr = seq_if.cur_addr;
            end
            default: state_d = S_RUN;
         endcase

         // Stack faults override whatever the op decoded to
         if (w_trap) begin
            w_jump     = 1'b1;
            w_jumpaddr = FAULT_VEC;
            fault_d    = 1'b1;
            state_d    = S_HALTED;
         end
      end
   end

   always_comb begin
      sp_d = sp_q;
      if (w_push) begin
         sp_d = sp_q + 1'b1;
      end else if (w_pop) begin
         sp_d = sp_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_RUN;
         sp_q     <= '0;
         in_isr_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sp_q     <= sp_d;
         in_isr_q <= in_isr_d;
         fault_q  <= fault_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         stack_q[sp_q[AW-1:0]] <= w_push_data;
      end
   end

   assign seq_if.jump     = w_jump;
   assign seq_if.jumpaddr = w_jumpaddr;
   assign seq_if.irq_ack  = w_irq_ack;
   assign seq_if.halted   = (state_q == S_HALTED) && !rst;
   assign seq_if.in_isr   = IRQ_EN && in_isr_q;
   assign seq_if.fault    = fault_q;
   assign seq_if.sp       = sp_q;

endmodule
`default_nettype wire
